shift_wb_buffer: RTL and testbench

SHIFT_WB_BUFFER -- requirements
Module: shift_wb_buffer

---
 rtl/shift_wb_buffer.sv | 141 ++++++++++++++
 tb/tb_shift_wb_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_wb_buffer.sv
// shift_wb_buffer
//   Small in-order FIFO that queues shift-unit results until the register
//   file accepts the write-back.
//
//   Parameters
//     DEPTH    entry count, power of two from 2 to 16
//     SKIP_R0  1: results targeting register 0 are dropped at the input
//
//   Ports
//     clock, reset          rising-edge clock, synchronous active-high reset
//     in_valid/in_result/in_rd   result strobe, {carry, data[31:0]}, dest reg
//     in_ready              push accepted this cycle (buffer not full)
//     flush                 synchronous discard of all buffered entries
//     wb_valid/wb_ready     write-back handshake
//     wb_rd/wb_data/wb_carry     head entry fields, 0 when empty
//     count                 occupied entries
//     overflow_err          sticky flag: a real result was refused
//
//   Optional feature: define SHIFT_WB_FLAGS_EN to add wb_zero / wb_neg,
//   computed at push time and stored with each entry.
module shift_wb_buffer #(
  parameter int DEPTH   = 4,
  parameter int SKIP_R0 = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [32:0]                in_result,
  input  logic [4:0]                 in_rd,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [4:0]                 wb_rd,
  output logic [31:0]                wb_data,
  output logic                       wb_carry,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
`ifdef SHIFT_WB_FLAGS_EN
  ,
  output logic                       wb_zero,
  output logic                       wb_neg
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic [4:0]    rd_mem    [DEPTH];
  logic [31:0]   data_mem  [DEPTH];
  logic          carry_mem [DEPTH];
`ifdef SHIFT_WB_FLAGS_EN
  logic          zero_mem  [DEPTH];
  logic          neg_mem   [DEPTH];
`endif

  logic full;
  logic empty;
  logic skip;
  logic push;
  logic pop;

  always_comb begin
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
    skip  = (SKIP_R0 != 0) && (in_rd == 5'd0);
    // A full buffer refuses pushes even when a pop frees a slot this cycle.
    push  = in_valid && !full && !flush && !skip;
    pop   = !empty && wb_ready && !flush;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (in_valid && full && !skip)
        overflow_q <= 1'b1;
      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        // Pointer wrap is the natural roll-over of a power-of-two index.
        if (push)
          tail_q <= tail_q + PW'(1);
        if (pop)
          head_q <= head_q + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage is not reset; outputs are masked while empty instead.
  always_ff @(posedge clock) begin
    if (push) begin
      rd_mem[tail_q]    <= in_rd;
      data_mem[tail_q]  <= in_result[31:0];
      carry_mem[tail_q] <= in_result[32];
`ifdef SHIFT_WB_FLAGS_EN
      zero_mem[tail_q]  <= (in_result[31:0] == 32'd0);
      neg_mem[tail_q]   <= in_result[31];
`endif
    end
  end

  always_comb begin
    in_ready     = !full;
    wb_valid     = !empty;
    count        = count_q;
    overflow_err = overflow_q;
    wb_rd        = '0;
    wb_data      = '0;
    wb_carry     = 1'b0;
`ifdef SHIFT_WB_FLAGS_EN
    wb_zero      = 1'b0;
    wb_neg       = 1'b0;
`endif
    if (!empty) begin
      wb_rd    = rd_mem[head_q];
      wb_data  = data_mem[head_q];
      wb_carry = carry_mem[head_q];
`ifdef SHIFT_WB_FLAGS_EN
      wb_zero  = zero_mem[head_q];
      wb_neg   = neg_mem[head_q];
`endif
    end
  end

endmodule

// File: tb/tb_shift_wb_buffer.sv
// Directed bench for shift_wb_buffer (DEPTH=4). A second instance with
// SKIP_R0=0 shares all inputs and is checked only for register-0 results.
module tb_shift_wb_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [32:0] in_result;
  logic [4:0]  in_rd;
  logic        flush;
  logic        wb_ready;

  logic        in_ready,  in_ready0;
  logic        wb_valid,  wb_valid0;
  logic [4:0]  wb_rd,     wb_rd0;
  logic [31:0] wb_data,   wb_data0;
  logic        wb_carry,  wb_carry0;
  logic [2:0]  count,     count0;
  logic        overflow_err, overflow_err0;
`ifdef SHIFT_WB_FLAGS_EN
  logic        wb_zero, wb_neg, wb_zero0, wb_neg0;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  shift_wb_buffer #(.DEPTH(4), .SKIP_R0(1)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_rd(in_rd), .in_ready(in_ready), .flush(flush), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data), .wb_carry(wb_carry),
    .count(count), .overflow_err(overflow_err)
`ifdef SHIFT_WB_FLAGS_EN
    , .wb_zero(wb_zero), .wb_neg(wb_neg)
`endif
  );

  shift_wb_buffer #(.DEPTH(4), .SKIP_R0(0)) u_dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_rd(in_rd), .in_ready(in_ready0), .flush(flush), .wb_valid(wb_valid0),
    .wb_ready(wb_ready), .wb_rd(wb_rd0), .wb_data(wb_data0), .wb_carry(wb_carry0),
    .count(count0), .overflow_err(overflow_err0)
`ifdef SHIFT_WB_FLAGS_EN
    , .wb_zero(wb_zero0), .wb_neg(wb_neg0)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic head(input string tag, input logic [4:0] rd, input logic [31:0] d, input logic c);
    check({tag, ".valid"}, 64'(wb_valid), 64'd1);
    check({tag, ".rd"},    64'(wb_rd),    64'(rd));
    check({tag, ".data"},  64'(wb_data),  64'(d));
    check({tag, ".carry"}, 64'(wb_carry), 64'(c));
  endtask

  task automatic push(input logic [4:0] rd, input logic [32:0] r);
    in_valid = 1'b1; in_rd = rd; in_result = r;
    tick();
    in_valid = 1'b0; in_rd = 5'd0; in_result = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_result = '0; in_rd = 5'd0;
    flush = 1'b0; wb_ready = 1'b0;
    do_reset();

    // Reset state
    check("rst.count",    64'(count),        64'd0);
    check("rst.valid",    64'(wb_valid),     64'd0);
    check("rst.ready",    64'(in_ready),     64'd1);
    check("rst.ovf",      64'(overflow_err), 64'd0);
    check("rst.rd",       64'(wb_rd),        64'd0);
    check("rst.data",     64'(wb_data),      64'd0);
    check("rst.carry",    64'(wb_carry),     64'd0);

    // Single push, one-cycle latency
    push(5'd3, 33'h0_0000_00F0);
    head("p1", 5'd3, 32'hF0, 1'b0);
    check("p1.count", 64'(count), 64'd1);

    // Fill to four with wb_ready low; head holds stable
    push(5'd4, 33'h1_0000_0011);
    check("hold1.rd", 64'(wb_rd), 64'd3);
    push(5'd5, 33'h0_0000_0022);
    push(5'd6, 33'h0_0000_0033);
    head("hold2", 5'd3, 32'hF0, 1'b0);
    check("full.count", 64'(count),    64'd4);
    check("full.ready", 64'(in_ready), 64'd0);

    // Fifth push refused, error sticky
    push(5'd7, 33'h0_0000_0044);
    check("ovf.set",   64'(overflow_err), 64'd1);
    check("ovf.count", 64'(count),        64'd4);
    head("ovf.head", 5'd3, 32'hF0, 1'b0);

    // Drain in order
    wb_ready = 1'b1;
    tick(); head("pop1", 5'd4, 32'h11, 1'b1);
    tick(); head("pop2", 5'd5, 32'h22, 1'b0);
    tick(); head("pop3", 5'd6, 32'h33, 1'b0);
    tick();
    check("drain.count", 64'(count),        64'd0);
    check("drain.valid", 64'(wb_valid),     64'd0);
    check("drain.data",  64'(wb_data),      64'd0);
    check("drain.ovf",   64'(overflow_err), 64'd1);
    wb_ready = 1'b0;

    // Refill across the pointer wrap, then push+pop while full
    push(5'd11, 33'h0_0000_0A01);
    push(5'd12, 33'h0_0000_0A02);
    push(5'd13, 33'h0_0000_0A03);
    push(5'd14, 33'h0_0000_0A04);
    head("wrap.head", 5'd11, 32'hA01, 1'b0);
    check("wrap.count", 64'(count), 64'd4);
    wb_ready = 1'b1; in_valid = 1'b1; in_rd = 5'd8; in_result = 33'h0_0000_0888;
    tick();
    in_valid = 1'b0; wb_ready = 1'b0;
    check("fullpp.count", 64'(count),        64'd3);
    check("fullpp.ovf",   64'(overflow_err), 64'd1);
    head("fullpp.head", 5'd12, 32'hA02, 1'b0);

    // Pop one to leave two, then flush with a concurrent push
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("two.count", 64'(count), 64'd2);
    flush = 1'b1; in_valid = 1'b1; in_rd = 5'd9; in_result = 33'h0_0000_0999;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.count", 64'(count),        64'd0);
    check("flush.valid", 64'(wb_valid),     64'd0);
    check("flush.rd",    64'(wb_rd),        64'd0);
    check("flush.ovf",   64'(overflow_err), 64'd1);
    push(5'd12, 33'h0_0000_000C);
    head("postflush", 5'd12, 32'hC, 1'b0);
    check("postflush.count", 64'(count), 64'd1);

    // Reset mid-stream beats a concurrent push
    reset = 1'b1; in_valid = 1'b1; in_rd = 5'd15; in_result = 33'h0_0000_0F0F;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("midrst.count", 64'(count),        64'd0);
    check("midrst.valid", 64'(wb_valid),     64'd0);
    check("midrst.ovf",   64'(overflow_err), 64'd0);

    // Register-0 results: dropped with SKIP_R0=1, stored with SKIP_R0=0
    push(5'd0, 33'h1_8000_0000);
    check("r0.count",  64'(count),        64'd0);
    check("r0.valid",  64'(wb_valid),     64'd0);
    check("r0.ovf",    64'(overflow_err), 64'd0);
    check("r0k.count", 64'(count0),       64'd1);
    check("r0k.valid", 64'(wb_valid0),    64'd1);
    check("r0k.rd",    64'(wb_rd0),       64'd0);
    check("r0k.data",  64'(wb_data0),     64'h8000_0000);
    check("r0k.carry", 64'(wb_carry0),    64'd1);

    // rd=0 offered while full never flags overflow
    push(5'd1, 33'h0_0000_0001);
    push(5'd2, 33'h0_0000_0002);
    push(5'd3, 33'h0_0000_0003);
    push(5'd4, 33'h0_0000_0004);
    push(5'd0, 33'h0_0000_0005);
    check("r0full.count", 64'(count),        64'd4);
    check("r0full.ovf",   64'(overflow_err), 64'd0);

    // Push and pop together when not full
    do_reset();
    push(5'd1, 33'h0_0000_0101);
    wb_ready = 1'b1; in_valid = 1'b1; in_rd = 5'd2; in_result = 33'h1_0000_0202;
    tick();
    wb_ready = 1'b0; in_valid = 1'b0;
    check("pp.count", 64'(count), 64'd1);
    head("pp.head", 5'd2, 32'h202, 1'b1);

`ifdef SHIFT_WB_FLAGS_EN
    do_reset();
    check("flg.rst.zero", 64'(wb_zero), 64'd0);
    push(5'd1, 33'h0_0000_0000);
    check("flg.zero", 64'(wb_zero), 64'd1);
    check("flg.neg0", 64'(wb_neg),  64'd0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    push(5'd2, 33'h0_8000_0000);
    check("flg.neg",   64'(wb_neg),  64'd1);
    check("flg.zero0", 64'(wb_zero), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
